// File: rtl/ro_sample_ctrl_if.sv
// Word handoff from the ring-oscillator sampler to the downstream absorber.
interface ro_sample_ctrl_if #(
  parameter int unsigned WORD_W = 64
) ();
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              word_ready;

  modport master (output word, output word_valid, input word_ready);
  modport slave  (input word, input word_valid, output word_ready);
endinterface

// File: rtl/ro_sample_ctrl.sv
// Ring-oscillator sample controller: warm-up, decimated bit collection, word handoff.
// Optional repetition-count health test enabled by defining RO_HEALTH_TEST_EN.
module ro_sample_ctrl #(
  parameter int unsigned WORD_W     = 64,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned WARM       = 16,
  parameter int unsigned RCT_CUTOFF = 31
) (
  input  logic              clk,
  input  logic              E,
  input  logic              start,
  input  logic              raw_bit,
  output logic              ro_en,
  output logic              flop_clr,
  output logic              busy,
  output logic              health_fail,
  ro_sample_ctrl_if.master  wif
);

  localparam int unsigned DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned WRM_W = (WARM > 1) ? $clog2(WARM) : 1;
  localparam int unsigned BIT_W = $clog2(WORD_W);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [WRM_W-1:0] WRM_LAST = WRM_W'(WARM - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  if (WORD_W < 2 || DECIM < 1 || WARM < 1 || RCT_CUTOFF < 2) begin : g_bad_params
    $error("ro_sample_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_COLLECT,
    S_HOLD,
    S_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [DEC_W-1:0]  dec_q, dec_d;
  logic [WRM_W-1:0]  wrm_q, wrm_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, ro_en_q, flop_clr_q, busy_q;
  logic              fail_det;

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    wrm_d   = wrm_q;
    bit_d   = bit_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WARMUP;
          wrm_d   = '0;
        end
      end
      S_WARMUP: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (wrm_q == WRM_LAST) begin
          state_d = S_COLLECT;
          dec_d   = '0;
          bit_d   = '0;
        end else begin
          wrm_d = wrm_q + 1'b1;
        end
      end
      S_COLLECT: begin
        if (fail_det) begin
          state_d = S_FAIL;
        end else if (!start) begin
          state_d = S_IDLE;
        end else if (dec_q == DEC_LAST) begin
          dec_d  = '0;
          word_d = {word_q[WORD_W-2:0], raw_bit};
          bit_d  = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = S_HOLD;
          end
        end else begin
          dec_d = dec_q + 1'b1;
        end
      end
      S_HOLD: begin
        // start is only consulted once the held word has been accepted
        if (fail_det) begin
          state_d = S_FAIL;
        end else if (valid_q && wif.word_ready) begin
          state_d = start ? S_COLLECT : S_IDLE;
          dec_d   = '0;
          bit_d   = '0;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    if (E) begin
      state_q    <= S_IDLE;
      dec_q      <= '0;
      wrm_q      <= '0;
      bit_q      <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      ro_en_q    <= 1'b0;
      flop_clr_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dec_q      <= dec_d;
      wrm_q      <= wrm_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      valid_q    <= (state_d == S_HOLD);
      ro_en_q    <= (state_d inside {S_WARMUP, S_COLLECT, S_HOLD});
      flop_clr_q <= (state_d inside {S_IDLE, S_WARMUP, S_FAIL});
      busy_q     <= (state_d != S_IDLE);
    end
  end

`ifdef RO_HEALTH_TEST_EN
  localparam int unsigned RUN_W = $clog2(RCT_CUTOFF + 1);
  localparam logic [RUN_W-1:0] RUN_CUT = RUN_W'(RCT_CUTOFF);

  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;
  logic             health_q;

  // run_q == 0 marks "no sample yet since entering COLLECT"
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    if (state_q != S_COLLECT && state_d == S_COLLECT) begin
      run_d = '0;
    end else if (state_q == S_COLLECT && dec_q == DEC_LAST) begin
      last_d = raw_bit;
      if (run_q == '0 || raw_bit != last_q) begin
        run_d = RUN_W'(1);
      end else if (run_q != RUN_CUT) begin
        run_d = run_q + 1'b1;
      end
    end
  end

  assign fail_det = (run_q >= RUN_CUT);

  always_ff @(posedge clk) begin
    if (E) begin
      run_q    <= '0;
      last_q   <= 1'b0;
      health_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      last_q   <= last_d;
      health_q <= (state_d == S_FAIL);
    end
  end

  assign health_fail = health_q;
`else
  assign fail_det    = 1'b0;
  assign health_fail = 1'b0;
`endif

  assign ro_en          = ro_en_q;
  assign flop_clr       = flop_clr_q;
  assign busy           = busy_q;
  assign wif.word       = word_q;
  assign wif.word_valid = valid_q;

endmodule

// File: tb/tb_ro_sample_ctrl.sv
// Directed bench for ro_sample_ctrl; health-test section selected by RO_HEALTH_TEST_EN.
module tb_ro_sample_ctrl;
  localparam int unsigned WORD_W = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ALT  = 64'h5555_5555_5555_5555;

  logic clk = 1'b0;
  logic E, start, raw_bit;
  logic ro_en, flop_clr, busy, health_fail;

  ro_sample_ctrl_if #(.WORD_W(WORD_W)) wif ();

  ro_sample_ctrl #(
    .WORD_W(WORD_W),
    .DECIM(4),
    .WARM(16),
    .RCT_CUTOFF(31)
  ) dut (
    .clk(clk),
    .E(E),
    .start(start),
    .raw_bit(raw_bit),
    .ro_en(ro_en),
    .flop_clr(flop_clr),
    .busy(busy),
    .health_fail(health_fail),
    .wif(wif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int e     = 0;
  int base  = 0;
  bit tog_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (edge %0d): got %h expected %h", tag, e, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs are changed #1 after it, outputs sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
    e++;
    if (tog_en && e >= base) raw_bit = (((e - base) >> 2) % 2) == 1;
  endtask

  task automatic run_to(input int tgt);
    while (e < tgt) step();
  endtask

  task automatic chk_rst_outs(input string tag);
    chk({tag, ".word"}, wif.word, 64'h0);
    chk({tag, ".valid"}, 64'(wif.word_valid), 64'd0);
    chk({tag, ".ro_en"}, 64'(ro_en), 64'd0);
    chk({tag, ".flop_clr"}, 64'(flop_clr), 64'd1);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".health"}, 64'(health_fail), 64'd0);
  endtask

  initial begin
    int bad;
    E = 1'b1;
    start = 1'b0;
    raw_bit = 1'b0;
    wif.word_ready = 1'b0;
    step();
    step();
    chk_rst_outs("reset");
    E = 1'b0;
    e = 0;

`ifdef RO_HEALTH_TEST_EN
    start = 1'b1;
    raw_bit = 1'b0;
    run_to(141);
    chk("hf_pre", 64'(health_fail), 64'd0);
    chk("hf_pre_roen", 64'(ro_en), 64'd1);
    step();
    chk("hf_set", 64'(health_fail), 64'd1);
    chk("hf_roen", 64'(ro_en), 64'd0);
    chk("hf_clr", 64'(flop_clr), 64'd1);
    chk("hf_valid", 64'(wif.word_valid), 64'd0);
    chk("hf_busy", 64'(busy), 64'd1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      start = (i % 3) != 0;
      wif.word_ready = i[0];
      step();
      if (health_fail !== 1'b1 || busy !== 1'b1 || ro_en !== 1'b0) bad++;
    end
    chk("hf_sticky", 64'(bad), 64'd0);
    E = 1'b1;
    step();
    chk_rst_outs("hf_reset");
    E = 1'b0;
`else
    // First word: constant ones
    start = 1'b1;
    raw_bit = 1'b1;
    step();
    chk("w_roen", 64'(ro_en), 64'd1);
    chk("w_clr", 64'(flop_clr), 64'd1);
    chk("w_busy", 64'(busy), 64'd1);
    run_to(16);
    chk("w_last_clr", 64'(flop_clr), 64'd1);
    step();
    chk("c_clr", 64'(flop_clr), 64'd0);
    chk("c_roen", 64'(ro_en), 64'd1);
    run_to(272);
    chk("pre_valid", 64'(wif.word_valid), 64'd0);
    step();
    chk("valid_273", 64'(wif.word_valid), 64'd1);
    chk("word_ones", wif.word, ONES);
    chk("hf_const0", 64'(health_fail), 64'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", 64'(wif.word_valid), 64'd1);
      chk("hold_word", wif.word, ONES);
    end

    // Second and third words: alternating bits, ready held high
    wif.word_ready = 1'b1;
    tog_en = 1'b1;
    base = 284;
    step();
    chk("acc_valid", 64'(wif.word_valid), 64'd0);
    chk("acc_busy", 64'(busy), 64'd1);
    chk("acc_clr", 64'(flop_clr), 64'd0);
    bad = 0;
    while (e < 539) begin
      step();
      if (flop_clr !== 1'b0 || wif.word_valid !== 1'b0) bad++;
    end
    chk("no_rewarm1", 64'(bad), 64'd0);
    step();
    chk("valid_540", 64'(wif.word_valid), 64'd1);
    chk("word_alt1", wif.word, ALT);
    base = 541;
    step();
    chk("acc2_valid", 64'(wif.word_valid), 64'd0);
    bad = 0;
    while (e < 796) begin
      step();
      if (flop_clr !== 1'b0 || wif.word_valid !== 1'b0) bad++;
    end
    chk("no_rewarm2", 64'(bad), 64'd0);
    step();
    chk("valid_797", 64'(wif.word_valid), 64'd1);
    chk("word_alt2", wif.word, ALT);

    // Stall in HOLD, drop start mid-hold, then release
    wif.word_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) start = 1'b0;
      step();
      chk("stall_valid", 64'(wif.word_valid), 64'd1);
      chk("stall_word", wif.word, ALT);
    end
    wif.word_ready = 1'b1;
    step();
    tog_en = 1'b0;
    wif.word_ready = 1'b0;
    chk("rel_valid", 64'(wif.word_valid), 64'd0);
    chk("rel_roen", 64'(ro_en), 64'd0);
    chk("rel_clr", 64'(flop_clr), 64'd1);
    chk("rel_busy", 64'(busy), 64'd0);
    chk("rel_word", wif.word, ALT);

    // Abort at cycle 100 of COLLECT
    e = 0;
    start = 1'b1;
    raw_bit = 1'b1;
    run_to(116);
    chk("ab_busy", 64'(busy), 64'd1);
    chk("ab_clr", 64'(flop_clr), 64'd0);
    start = 1'b0;
    step();
    chk("ab_roen", 64'(ro_en), 64'd0);
    chk("ab_clr2", 64'(flop_clr), 64'd1);
    chk("ab_busy2", 64'(busy), 64'd0);
    chk("ab_word", wif.word, 64'h5555_5555_55FF_FFFF);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (wif.word_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("ab_idle", 64'(bad), 64'd0);

    // Reset while holding a valid word
    e = 0;
    start = 1'b1;
    run_to(273);
    chk("r_valid", 64'(wif.word_valid), 64'd1);
    E = 1'b1;
    step();
    chk_rst_outs("hold_reset");
    E = 1'b0;
    start = 1'b0;
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
